// File: rtl/video_sync_recover.sv
`default_nettype none
// ============================================================================
// Module   : video_sync_recover
// Purpose  : Recovers pixel/line/frame timing from a core's raw hsync/vsync.
//            Generates a pixel clock-enable from clk_sys, normalises sync
//            polarity, tracks hcount/vcount, measures line length and frame
//            height, derives blanking windows and reports when the measured
//            frame timing has been stable for LOCK_FRAMES frames.
// Ports    : clk_sys      - the only clock
//            reset        - asynchronous active-high reset
//            hs_in/vs_in  - raw sync inputs
//            hs_pol/vs_pol- 1 = corresponding sync input is active-high
//            ce_pix       - one-cycle pixel enable, cycle after each tick
//            hcount/vcount- pixel within line / line within frame
//            hblank/vblank- blanking windows decoded from hcount/vcount
//            hsync/vsync  - registered, active-high syncs
//            line_len     - pixel ticks in the last complete line
//            frame_lines  - lines in the last complete frame
//            locked       - frame timing stable
// Revision : 1.0 - initial release
// ============================================================================
module video_sync_recover #(
    parameter int CE_DIV      = 16,
    parameter int CW          = 10,
    parameter int HB_START    = 214,
    parameter int HB_END      = 34,
    parameter int VB_START    = 255,
    parameter int VB_END      = 25,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hs_pol,
    input  logic          vs_pol,
    output logic          ce_pix,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] line_len,
    output logic [CW-1:0] frame_lines,
    output logic          locked
);

    localparam int DW = $clog2(CE_DIV);
    localparam int MW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CW-1:0] c_CMAX     = '1;
    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [CW-1:0] c_HB_START = CW'(HB_START);
    localparam logic [CW-1:0] c_HB_END   = CW'(HB_END);
    localparam logic [CW-1:0] c_VB_START = CW'(VB_START);
    localparam logic [CW-1:0] c_VB_END   = CW'(VB_END);
    localparam logic [MW-1:0] c_LOCK     = MW'(LOCK_FRAMES);
    localparam logic [DW-1:0] c_DIV_ONE  = DW'(1);
    localparam logic [MW-1:0] c_M_ONE    = MW'(1);

    logic [DW-1:0] r_div;
    logic          r_ce;
    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_vs_line;     // vsync as sampled at the last h-edge
    logic [CW-1:0] r_line_len;
    logic [CW-1:0] r_frame_lines;
    logic [CW-1:0] r_vedge_len;   // line_len captured at the last v-edge
    logic [MW-1:0] r_match;
    logic          r_locked;

    logic          w_tick;
    logic          w_hs_eff;
    logic          w_vs_eff;
    logic          w_hedge;
    logic          w_vedge;
    logic          w_h_sat;
    logic [CW-1:0] w_h_inc;
    logic [CW-1:0] w_v_inc;
    logic          w_match_hit;
    logic [MW-1:0] w_match_next;

    assign w_tick   = &r_div;
    assign w_hs_eff = ~(hs_in ^ hs_pol);
    assign w_vs_eff = ~(vs_in ^ vs_pol);
    assign w_hedge  = w_tick & w_hs_eff & ~r_hsync;
    // Vertical edges are judged only at line starts, against the vsync level
    // seen at the previous line start, so vsync skew inside a line is ignored.
    assign w_vedge  = w_hedge & w_vs_eff & ~r_vs_line;

    assign w_h_sat  = (r_hcount == c_CMAX);
    assign w_h_inc  = w_h_sat ? c_CMAX : (r_hcount + c_ONE);
    assign w_v_inc  = (r_vcount == c_CMAX) ? c_CMAX : (r_vcount + c_ONE);

    // w_v_inc / w_h_inc are the frame height and line length being captured
    // at this v-edge; compare them with what the previous v-edge captured.
    assign w_match_hit = (w_v_inc == r_frame_lines) &&
                         (r_frame_lines != '0) &&
                         (w_h_inc == r_vedge_len);

    always_comb begin
        w_match_next = r_match;
        if (w_vedge) begin
            if (w_match_hit) begin
                w_match_next = (r_match == c_LOCK) ? r_match : (r_match + c_M_ONE);
            end else begin
                w_match_next = '0;
            end
        end
        // A saturated hcount means hsync has vanished: drop lock.
        if (w_tick && w_h_sat) begin
            w_match_next = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div         <= '0;
            r_ce          <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_vs_line     <= 1'b0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_vedge_len   <= '0;
            r_match       <= '0;
            r_locked      <= 1'b0;
        end else begin
            r_div <= r_div + c_DIV_ONE;
            r_ce  <= w_tick;
            if (w_tick) begin
                r_hsync  <= w_hs_eff;
                r_vsync  <= w_vs_eff;
                r_match  <= w_match_next;
                r_locked <= (w_match_next == c_LOCK);
                if (w_hedge) begin
                    r_hcount   <= '0;
                    r_line_len <= w_h_inc;
                    r_vs_line  <= w_vs_eff;
                    if (w_vedge) begin
                        r_vcount      <= '0;
                        r_frame_lines <= w_v_inc;
                        r_vedge_len   <= w_h_inc;
                    end else begin
                        r_vcount <= w_v_inc;
                    end
                end else begin
                    r_hcount <= w_h_inc;
                end
            end
        end
    end

    assign ce_pix      = r_ce;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = r_locked;
    assign hblank      = (r_hcount >= c_HB_START) || (r_hcount < c_HB_END);
    assign vblank      = (r_vcount >= c_VB_START) || (r_vcount < c_VB_END);

endmodule
`default_nettype wire

// File: tb/tb_video_sync_recover.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_sync_recover
// Purpose  : Self-checking bench for video_sync_recover. A scaled instance is
//            driven with generated line/frame sync patterns and compared every
//            cycle against a behavioural model; a default-parameter instance
//            checks the pixel-enable cadence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_sync_recover;

    localparam int CE_DIV = 4;
    localparam int CW     = 6;
    localparam int HBS    = 16;
    localparam int HBE    = 3;
    localparam int VBS    = 10;
    localparam int VBE    = 2;
    localparam int LOCK   = 2;
    localparam int MAXC   = (1 << CW) - 1;

    logic clk_sys = 1'b0;
    logic reset   = 1'b0;
    logic hs_in   = 1'b0;
    logic vs_in   = 1'b0;
    logic hs_pol  = 1'b1;
    logic vs_pol  = 1'b1;

    logic          ce_pix, hblank, vblank, hsync, vsync, locked;
    logic [CW-1:0] hcount, vcount, line_len, frame_lines;

    logic          d_ce, d_hb, d_vb, d_hs, d_vs, d_lk;
    logic [9:0]    d_h, d_v, d_ll, d_fl;

    video_sync_recover #(
        .CE_DIV(CE_DIV), .CW(CW), .HB_START(HBS), .HB_END(HBE),
        .VB_START(VBS), .VB_END(VBE), .LOCK_FRAMES(LOCK)
    ) u_dut (
        .clk_sys(clk_sys), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .ce_pix(ce_pix), .hcount(hcount),
        .vcount(vcount), .hblank(hblank), .vblank(vblank), .hsync(hsync),
        .vsync(vsync), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked)
    );

    video_sync_recover u_def (
        .clk_sys(clk_sys), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .ce_pix(d_ce), .hcount(d_h),
        .vcount(d_v), .hblank(d_hb), .vblank(d_vb), .hsync(d_hs),
        .vsync(d_vs), .line_len(d_ll), .frame_lines(d_fl), .locked(d_lk)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_div, m_cyc, m_h, m_v, m_ll, m_fl, m_prev_ll, m_match;
    bit m_ce, m_hs, m_vs, m_vsl, m_locked, m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic model_reset();
        m_div = 0; m_cyc = 0; m_h = 0; m_v = 0; m_ll = 0; m_fl = 0;
        m_prev_ll = 0; m_match = 0; m_ce = 0; m_hs = 0; m_vs = 0;
        m_vsl = 0; m_locked = 0; m_tick = 0;
    endtask

    // One clk_sys edge of the recovered timing, in terms of pixel ticks,
    // line starts and frame starts.
    task automatic model_step();
        bit hs_e, vs_e, line_start, frame_start, lost;
        int new_ll, new_fl;
        m_tick = (m_div == CE_DIV - 1);
        m_div  = (m_div + 1) % CE_DIV;
        m_cyc++;
        m_ce   = m_tick;
        if (m_tick) begin
            hs_e        = (hs_in == hs_pol);
            vs_e        = (vs_in == vs_pol);
            line_start  = hs_e && !m_hs;
            frame_start = line_start && vs_e && !m_vsl;
            lost        = (m_h == MAXC);
            m_hs = hs_e;
            m_vs = vs_e;
            if (line_start) begin
                new_ll = sat(m_h + 1);
                m_vsl  = vs_e;
                if (frame_start) begin
                    new_fl = sat(m_v + 1);
                    if (new_fl == m_fl && m_fl != 0 && new_ll == m_prev_ll)
                        m_match = (m_match < LOCK) ? m_match + 1 : LOCK;
                    else
                        m_match = 0;
                    m_fl      = new_fl;
                    m_prev_ll = new_ll;
                    m_v       = 0;
                end else begin
                    m_v = sat(m_v + 1);
                end
                m_ll = new_ll;
                m_h  = 0;
            end else begin
                m_h = sat(m_h + 1);
            end
            if (lost) m_match = 0;
            m_locked = (m_match == LOCK);
        end
    endtask

    task automatic check_all();
        chk("ce_pix", ce_pix, m_ce);
        chk("hcount", hcount, m_h);
        chk("vcount", vcount, m_v);
        chk("hsync", hsync, m_hs);
        chk("vsync", vsync, m_vs);
        chk("line_len", line_len, m_ll);
        chk("frame_lines", frame_lines, m_fl);
        chk("locked", locked, m_locked);
        chk("hblank", hblank, (m_h >= HBS || m_h < HBE));
        chk("vblank", vblank, (m_v >= VBS || m_v < VBE));
        chk("def_ce_pix", d_ce, (m_cyc > 0 && (m_cyc % 16) == 0));
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic tick_wait();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!m_tick && n < 2 * CE_DIV);
        if (!m_tick) begin
            checks++;
            errors++;
            $error("FAIL tick_wait observed=no_tick expected=tick");
        end
    endtask

    task automatic send_line(input int len, input int hsw, input bit vact);
        for (int t = 0; t < len; t++) begin
            hs_in = (t < hsw) ? hs_pol : ~hs_pol;
            vs_in = vact ? vs_pol : ~vs_pol;
            tick_wait();
        end
    endtask

    task automatic send_frame_from(input int start, input int lines, input int len,
                                   input int hsw, input int vsw);
        for (int l = start; l < lines; l++) send_line(len, hsw, (l < vsw));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int len, lines, hsw, vsw;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check_all();
        chk("rst_hblank", hblank, 1);
        chk("rst_vblank", vblank, 1);
        chk("rst_locked", locked, 0);
        repeat (3) cycle();
        reset = 1'b0;
        hs_in = ~hs_pol;
        vs_in = ~vs_pol;
        repeat (50) cycle();

        // Stable active-high timing: 20-tick lines, 12-line frames
        repeat (6) send_frame_from(0, 12, 20, 3, 2);
        send_line(20, 3, 1'b1);
        chk("hi_line_len", line_len, 20);
        chk("hi_frame_lines", frame_lines, 12);
        chk("hi_locked", locked, 1);

        // One long frame breaks lock at the v-edge that ends it
        send_frame_from(1, 13, 20, 3, 2);
        send_line(20, 3, 1'b1);
        chk("long_frame_lines", frame_lines, 13);
        chk("long_frame_locked", locked, 0);
        send_frame_from(1, 12, 20, 3, 2);

        // Active-low syncs give identical measurements
        hs_pol = 1'b0;
        vs_pol = 1'b0;
        repeat (6) send_frame_from(0, 12, 20, 3, 2);
        send_line(20, 3, 1'b1);
        chk("lo_line_len", line_len, 20);
        chk("lo_frame_lines", frame_lines, 12);
        chk("lo_locked", locked, 1);
        chk("lo_vsync_active_high", vsync, 1);
        chk("lo_hsync_idle_low", hsync, 0);
        send_frame_from(1, 12, 20, 3, 2);

        // Randomised timings and polarity flips
        repeat (8) begin
            len   = $urandom_range(14, 30);
            lines = $urandom_range(6, 20);
            hsw   = $urandom_range(1, 4);
            vsw   = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) hs_pol = ~hs_pol;
            if ($urandom_range(0, 3) == 0) vs_pol = ~vs_pol;
            repeat ($urandom_range(0, 7)) cycle();
            repeat (2) send_frame_from(0, lines, len, hsw, vsw);
        end

        // Sync loss
        hs_pol = 1'b1;
        vs_pol = 1'b1;
        repeat (4) send_frame_from(0, 12, 20, 3, 2);
        send_line(20, 3, 1'b1);
        chk("preloss_locked", locked, 1);
        hs_in = ~hs_pol;
        repeat (70) tick_wait();
        chk("loss_hcount", hcount, MAXC);
        chk("loss_vcount", vcount, 0);
        chk("loss_locked", locked, 0);

        // Reset in the middle of a frame
        repeat (4) send_frame_from(0, 12, 20, 3, 2);
        send_frame_from(0, 6, 20, 3, 2);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("mid_rst_vcount", vcount, 0);
        chk("mid_rst_frame_lines", frame_lines, 0);
        chk("mid_rst_line_len", line_len, 0);
        repeat (2) cycle();
        reset = 1'b0;
        repeat (3) send_frame_from(0, 12, 20, 3, 2);
        chk("relock_not_yet", locked, 0);
        send_line(20, 3, 1'b1);
        chk("relock_done", locked, 1);
        chk("relock_frame_lines", frame_lines, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
